// File: rtl/sky130_fd_io__power_lvc_seq.sv
// Power sequencer for the low-voltage-clamp pad group: synchronises and debounces both
// power-good inputs, then releases ENABLE_H, HLD_H_N and AMUX isolation in order.
module sky130_fd_io__power_lvc_seq #(
  parameter int DEB_CYCLES  = 16,
  parameter int STEP_CYCLES = 8,
  parameter int CW          = 8
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       VDDIO_PGOOD,
  input  logic       VCCD_PGOOD,
  input  logic       SEQ_EN,
  output logic       ENABLE_H,
  output logic       HLD_H_N,
  output logic       AMUX_ISO,
  output logic       READY,
  output logic       FAULT,
  output logic [2:0] STATE
);

  localparam logic [CW-1:0] DEB_MAX   = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_WAIT_IO   = 3'd1,
    S_WAIT_CORE = 3'd2,
    S_PWR_EN    = 3'd3,
    S_REL_HOLD  = 3'd4,
    S_ON        = 3'd5,
    S_SHUT      = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  logic [1:0] raw;
  logic [1:0] good;
  assign raw = {VCCD_PGOOD, VDDIO_PGOOD};

  // Channel 0 is VDDIO, channel 1 is VCCD; a low synchronised sample drops good at once.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic [1:0]    sync_reg;
      logic [CW-1:0] cnt_reg;
      always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
          sync_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          sync_reg <= {sync_reg[0], raw[gi]};
          if (!sync_reg[1])
            cnt_reg <= '0;
          else if (cnt_reg != DEB_MAX)
            cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign good[gi] = sync_reg[1] & (cnt_reg == DEB_MAX);
    end
  endgenerate

  logic io_good, core_good, supply_ok, step_done;
  assign io_good   = good[0];
  assign core_good = good[1];
  assign supply_ok = io_good & core_good;

  state_t        state_reg, state_next;
  logic [CW-1:0] step_reg, step_next;
  logic          enable_reg, enable_next;
  logic          hold_n_reg, hold_n_next;
  logic          iso_reg, iso_next;
  logic          ready_reg, ready_next;
  logic          fault_reg, fault_next;

  assign step_done = (step_reg == STEP_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_OFF:       if (SEQ_EN) state_next = S_WAIT_IO;
      S_WAIT_IO:   if (!SEQ_EN) state_next = S_OFF;
                   else if (io_good) state_next = S_WAIT_CORE;
      S_WAIT_CORE: if (!SEQ_EN) state_next = S_OFF;
                   else if (!io_good) state_next = S_WAIT_IO;
                   else if (core_good) state_next = S_PWR_EN;
      S_PWR_EN:    if (!supply_ok) state_next = S_FAULT;
                   else if (!SEQ_EN) state_next = S_SHUT;
                   else if (step_done) state_next = S_REL_HOLD;
      S_REL_HOLD:  if (!supply_ok) state_next = S_FAULT;
                   else if (!SEQ_EN) state_next = S_SHUT;
                   else if (step_done) state_next = S_ON;
      S_ON:        if (!supply_ok) state_next = S_FAULT;
                   else if (!SEQ_EN) state_next = S_SHUT;
      S_SHUT:      if (!supply_ok) state_next = S_FAULT;
                   else if (step_done) state_next = S_OFF;
      S_FAULT:     if (!SEQ_EN) state_next = S_OFF;
      default:     state_next = S_OFF;
    endcase

    // Dwell counter restarts on every state change so each timed state lasts STEP_CYCLES.
    step_next = '0;
    if (state_next == state_reg &&
        (state_reg == S_PWR_EN || state_reg == S_REL_HOLD || state_reg == S_SHUT))
      step_next = step_reg + 1'b1;

    enable_next = (state_next == S_PWR_EN) || (state_next == S_REL_HOLD) ||
                  (state_next == S_ON) || (state_next == S_SHUT);
    hold_n_next = (state_next == S_REL_HOLD) || (state_next == S_ON);
    iso_next    = (state_next != S_ON);
    ready_next  = (state_next == S_ON);
    fault_next  = (state_next == S_FAULT);
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_reg  <= S_OFF;
      step_reg   <= '0;
      enable_reg <= 1'b0;
      hold_n_reg <= 1'b0;
      iso_reg    <= 1'b1;
      ready_reg  <= 1'b0;
      fault_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      step_reg   <= step_next;
      enable_reg <= enable_next;
      hold_n_reg <= hold_n_next;
      iso_reg    <= iso_next;
      ready_reg  <= ready_next;
      fault_reg  <= fault_next;
    end
  end

  assign ENABLE_H = enable_reg;
  assign HLD_H_N  = hold_n_reg;
  assign AMUX_ISO = iso_reg;
  assign READY    = ready_reg;
  assign FAULT    = fault_reg;
  assign STATE    = state_reg;

endmodule

// File: tb/tb_sky130_fd_io__power_lvc_seq.sv
// Bench for the LVC power sequencer: vector table, corner-case sequences and a random
// run checked against a cycle-count based reference model.
module tb_sky130_fd_io__power_lvc_seq;
  localparam int DEB  = 4;
  localparam int STEP = 3;

  logic CLK = 1'b0;
  logic RESET_B = 1'b0;
  logic VDDIO_PGOOD = 1'b0;
  logic VCCD_PGOOD = 1'b0;
  logic SEQ_EN = 1'b0;
  logic ENABLE_H, HLD_H_N, AMUX_ISO, READY, FAULT;
  logic [2:0] STATE;

  sky130_fd_io__power_lvc_seq #(.DEB_CYCLES(DEB), .STEP_CYCLES(STEP), .CW(8)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .VDDIO_PGOOD(VDDIO_PGOOD), .VCCD_PGOOD(VCCD_PGOOD),
    .SEQ_EN(SEQ_EN), .ENABLE_H(ENABLE_H), .HLD_H_N(HLD_H_N), .AMUX_ISO(AMUX_ISO),
    .READY(READY), .FAULT(FAULT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  logic [7:0] dut_vec;
  assign dut_vec = {STATE, ENABLE_H, HLD_H_N, AMUX_ISO, READY, FAULT};

  int vectors = 0;
  int miscompares = 0;

  // Reference model: raw run lengths (in edges) decide "good"; dwell is measured in edges since entry.
  int t = 0;
  int m_state = 0;
  int m_entry = 0;
  int run_io0 = 0, run_io1 = 0, run_core0 = 0, run_core1 = 0;

  function automatic logic [7:0] expect_vec(int st);
    logic en, hld, iso, rdy, flt;
    en  = (st >= 3 && st <= 6);
    hld = (st == 4 || st == 5);
    iso = (st != 5);
    rdy = (st == 5);
    flt = (st == 7);
    return {3'(st), en, hld, iso, rdy, flt};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_entry = t;
    run_io0 = 0; run_io1 = 0; run_core0 = 0; run_core1 = 0;
  endtask

  task automatic model_edge(bit seq, bit io, bit core);
    bit gio, gcore, ok, done;
    int nxt;
    t++;
    gio   = (run_io1 >= DEB + 1);
    gcore = (run_core1 >= DEB + 1);
    ok    = gio && gcore;
    done  = ((t - m_entry) == STEP);
    nxt   = m_state;
    case (m_state)
      0: if (seq) nxt = 1;
      1: if (!seq) nxt = 0; else if (gio) nxt = 2;
      2: if (!seq) nxt = 0; else if (!gio) nxt = 1; else if (gcore) nxt = 3;
      3: if (!ok) nxt = 7; else if (!seq) nxt = 6; else if (done) nxt = 4;
      4: if (!ok) nxt = 7; else if (!seq) nxt = 6; else if (done) nxt = 5;
      5: if (!ok) nxt = 7; else if (!seq) nxt = 6;
      6: if (!ok) nxt = 7; else if (done) nxt = 0;
      default: if (!seq) nxt = 0;
    endcase
    if (nxt != m_state) m_entry = t;
    m_state = nxt;
    run_io1   = run_io0;
    run_core1 = run_core0;
    run_io0   = io   ? ((run_io0 < 1000) ? run_io0 + 1 : 1000) : 0;
    run_core0 = core ? ((run_core0 < 1000) ? run_core0 + 1 : 1000) : 0;
  endtask

  task automatic check(string name, logic [7:0] got, logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
               name, got[7:5], got[4:0], exp[7:5], exp[4:0]);
    end
  endtask

  // Drive inputs away from the edge, clock once, sample 1ns after the edge.
  task automatic apply(bit seq, bit io, bit core);
    SEQ_EN = seq; VDDIO_PGOOD = io; VCCD_PGOOD = core;
    @(posedge CLK);
    model_edge(seq, io, core);
    #1;
  endtask

  task automatic do_reset(string name);
    RESET_B = 1'b0;
    #2;
    check(name, dut_vec, 8'b000_00100);
    $display("reset %s: state=%0d outs=%b", name, STATE, dut_vec[4:0]);
    model_reset();
    #2;
    RESET_B = 1'b1;
  endtask

  typedef struct {
    bit         seq;
    bit         io;
    bit         core;
    logic [2:0] st;
  } vec_t;
  vec_t tbl[$];

  task automatic add(bit seq, bit io, bit core, int st, int n);
    vec_t v;
    v.seq = seq; v.io = io; v.core = core; v.st = 3'(st);
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic add_powerup_tail();
    add(1, 1, 1, 2, 1); add(1, 1, 1, 3, 3); add(1, 1, 1, 4, 3); add(1, 1, 1, 5, 1);
  endtask

  initial begin
    int n;
    bit seq_r, io_r, core_r;

    // Power-up, shutdown, fault and recovery, simultaneous fault/shutdown.
    add(0, 1, 1, 0, 6);
    add(1, 1, 1, 1, 1); add_powerup_tail(); add(1, 1, 1, 5, 2);
    add(0, 1, 1, 6, 3); add(0, 1, 1, 0, 2);
    add(1, 1, 1, 1, 1); add_powerup_tail();
    add(1, 0, 1, 5, 2); add(1, 0, 1, 7, 2);
    add(1, 1, 1, 7, 6); add(0, 1, 1, 0, 2);
    add(1, 1, 1, 1, 1); add_powerup_tail();
    add(0, 1, 1, 6, 1); add(1, 1, 1, 6, 2); add(1, 1, 1, 0, 1);
    add(1, 1, 1, 1, 1); add(1, 1, 1, 2, 1); add(1, 1, 1, 3, 3); add(1, 1, 1, 4, 1);
    add(1, 1, 0, 4, 2); add(0, 1, 0, 7, 1); add(0, 1, 0, 0, 1);

    #7;
    do_reset("initial");
    foreach (tbl[i]) begin
      apply(tbl[i].seq, tbl[i].io, tbl[i].core);
      check($sformatf("table[%0d]", i), dut_vec, expect_vec(int'(tbl[i].st)));
      $display("vec %0d: seq=%0d io=%0d core=%0d state=%0d outs=%b",
               i, tbl[i].seq, tbl[i].io, tbl[i].core, STATE, dut_vec[4:0]);
    end

    // Debounce glitch on VCCD: a single low sample restarts the debounce.
    do_reset("pre-glitch");
    for (int i = 0; i < 6; i++) apply(0, 1, 0);
    apply(1, 1, 0);
    apply(1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 1);
      check("glitch_high", dut_vec, expect_vec(2));
    end
    apply(1, 1, 0);
    check("glitch_low", dut_vec, expect_vec(2));
    for (int i = 0; i < 7; i++) begin
      apply(1, 1, 1);
      check($sformatf("glitch_after[%0d]", i), dut_vec, expect_vec(i < 6 ? 2 : 3));
      $display("glitch %0d: state=%0d", i, STATE);
    end

    // Reset pulsed in REL_HOLD, then a full re-sequence from cold synchronisers.
    for (int i = 0; i < 3; i++) apply(1, 1, 1);
    check("pre_reset_rel_hold", dut_vec, expect_vec(4));
    do_reset("mid_sequence");
    n = 0;
    while (READY !== 1'b1 && n < 40) begin
      apply(1, 1, 1);
      n++;
      check($sformatf("resequence[%0d]", n), dut_vec, expect_vec(m_state));
    end
    vectors++;
    if (n != 14) begin
      miscompares++;
      $display("FAIL ready_latency: got %0d cycles, expected 14", n);
    end
    $display("resequence: READY after %0d cycles", n);

    // Random run against the model.
    seq_r = 0; io_r = 1; core_r = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) seq_r = ~seq_r;
      if (io_r) io_r = ($urandom_range(0, 79) != 0);
      else      io_r = ($urandom_range(0, 5) == 0);
      if (core_r) core_r = ($urandom_range(0, 79) != 0);
      else        core_r = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 599) == 0) do_reset($sformatf("random_reset[%0d]", i));
      apply(seq_r, io_r, core_r);
      check($sformatf("random[%0d]", i), dut_vec, expect_vec(m_state));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
